// File: rtl/arb4_bus_pkg.sv
// Shared types and constants for the four-requester round-robin bus arbiter.
// The optional lock feature elsewhere is enabled with the ARB_LOCK_EN macro.
package arb4_bus_pkg;

  localparam int NREQ = 4;

  typedef logic [63:0] word_t;
  typedef logic [1:0]  src_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  function automatic logic [NREQ-1:0] onehot4(input src_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arb4_bus_rr_pick4.sv
// Rotating first-valid search: starting at 'start' and moving upward modulo 4,
// report the first set bit of 'valid'.
module rr_pick4
  import arb4_bus_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  src_t            start,
  output logic            found,
  output src_t            index
);

  src_t cand;

  // Walk the offsets from farthest to nearest so the nearest valid one is
  // the last assignment and therefore wins.
  always_comb begin
    found = 1'b0;
    index = start;
    cand  = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start + src_t'(k);
      if (valid[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/arb4_bus.sv
// Four-requester round-robin arbiter feeding a one-entry registered output slot.
// Define ARB_LOCK_EN to let a winner hold the bus across beats via req_lock.
module arb4_bus
  import arb4_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][63:0] req_data,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [63:0]           out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready
);

  slot_state_t     state_q, state_d;
  word_t           data_q, data_d;
  src_t            src_q, src_d;
  src_t            rr_q, rr_d;
  logic [NREQ-1:0] eligible;
  logic            found;
  src_t            winner;
  logic            slot_free;
  logic            grant;

`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
  src_t owner_q, owner_d;

  // While locked, only the owner may compete.
  assign eligible = lock_q ? (req_valid & onehot4(owner_q)) : req_valid;
`else
  logic lock_unused;

  assign lock_unused = ^req_lock;
  assign eligible    = req_valid;
`endif

  rr_pick4 u_pick (
    .valid (eligible),
    .start (rr_q),
    .found (found),
    .index (winner)
  );

  // Reset gates the grant so req_ready drops as soon as reset rises.
  assign slot_free = (state_q == EMPTY) || out_ready;
  assign grant     = slot_free && found && !reset;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    src_d     = src_q;
    rr_d      = rr_q;
    req_ready = '0;
`ifdef ARB_LOCK_EN
    lock_d    = lock_q;
    owner_d   = owner_q;
`endif
    if (grant) begin
      req_ready = onehot4(winner);
      state_d   = FULL;
      data_d    = req_data[winner];
      src_d     = winner;
      rr_d      = winner + 2'd1;
`ifdef ARB_LOCK_EN
      if (req_lock[winner]) begin
        lock_d  = 1'b1;
        owner_d = winner;
      end else if (lock_q) begin
        lock_d  = 1'b0;
      end
`endif
    end else if (slot_free) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      rr_q    <= '0;
`ifdef ARB_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
`ifdef ARB_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_arb4_bus.sv
// Self-checking bench for arb4_bus: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_arb4_bus;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][63:0] req_data;
  logic [3:0]       req_lock;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int n_vec = 0;
  int n_err = 0;
  bit pin_beef = 0;

  bit          m_full;
  logic [63:0] m_data;
  int          m_src;
  int          m_rr;
  bit          m_lock;
  int          m_owner;

  arb4_bus dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_full  = 0;
    m_data  = '0;
    m_src   = 0;
    m_rr    = 0;
    m_lock  = 0;
    m_owner = 0;
  endtask

  // The requester that must be granted this cycle, or -1 when nobody is.
  function automatic int modelWinner();
    if (reset) return -1;
    if (m_full && !out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_rr + k) % 4;
      if (req_valid[i] && (!m_lock || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic modelAdvance();
    int w;
    w = modelWinner();
    if (w >= 0) begin
      m_full = 1;
      m_data = req_data[w];
      m_src  = w;
      m_rr   = (w + 1) % 4;
`ifdef ARB_LOCK_EN
      if (req_lock[w]) begin
        m_lock  = 1;
        m_owner = w;
      end else if (w == m_owner) begin
        m_lock = 0;
      end
`endif
    end else if (!m_full || out_ready) begin
      m_full = 0;
    end
  endtask

  task automatic checkOutput();
    int w;
    w = modelWinner();
    checkVal("req_ready", {60'd0, req_ready}, (w < 0) ? 64'd0 : (64'd1 << w));
    checkVal("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    if (m_full || reset) begin
      checkVal("out_data", out_data, m_data);
      checkVal("out_src", {62'd0, out_src}, 64'(m_src));
    end
  endtask

  // Compare process: checks the DUT against the model, then advances the model.
  always @(negedge clk) begin
    if (reset) modelReset();
    checkOutput();
    if (!reset) modelAdvance();
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] lk, input logic o);
    req_valid = v;
    req_lock  = lk;
    out_ready = o;
    for (int i = 0; i < 4; i++) req_data[i] = {$urandom, $urandom};
    if (pin_beef) req_data[0] = 64'hDEAD_BEEF;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] lk, input logic o,
                      input logic [3:0] exp_rdy, input string nm);
    applyStimulus(v, lk, o);
    @(negedge clk);
    #1;
    checkVal({nm, "_rdy"}, {60'd0, req_ready}, {60'd0, exp_rdy});
  endtask

  logic [63:0] held;
  logic [3:0]  lock_rdy [4];
  logic [1:0]  lock_src [4];

  initial begin
    reset = 1'b1;
    applyStimulus(4'hF, 4'h0, 1'b1);
    nextCycle();
    checkVal("rst_valid", {63'd0, out_valid}, 64'd0);
    checkVal("rst_data", out_data, 64'd0);
    checkVal("rst_src", {62'd0, out_src}, 64'd0);
    checkVal("rst_ready", {60'd0, req_ready}, 64'd0);
    nextCycle();
    reset = 1'b0;

    // All four valid, consumer always ready: grants rotate 0,1,2,3.
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 4'h0, 1'b1, 4'(1 << k), "rotate");
      if (k > 0) checkVal("rotate_src", {62'd0, out_src}, 64'(k - 1));
      nextCycle();
    end
    step(4'h0, 4'h0, 1'b1, 4'h0, "rotate_tail");
    checkVal("rotate_src3", {62'd0, out_src}, 64'd3);
    checkVal("rotate_valid", {63'd0, out_valid}, 64'd1);
    nextCycle();

    // Back-pressure: requester 1 held until the consumer frees the slot.
    step(4'b1010, 4'h0, 1'b0, 4'b0010, "hold");
    held = req_data[1];
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      step(4'b1010, 4'h0, 1'b0, 4'b0000, "hold_wait");
      checkVal("hold_src", {62'd0, out_src}, 64'd1);
      checkVal("hold_data", out_data, held);
      nextCycle();
    end
    step(4'b1010, 4'h0, 1'b1, 4'b1000, "hold_release");
    checkVal("hold_data_rel", out_data, held);
    nextCycle();

    // Wrap: pointer at 3 with only requester 0 valid.
    step(4'b0100, 4'h0, 1'b1, 4'b0100, "wrap_pre");
    nextCycle();
    step(4'b0001, 4'h0, 1'b1, 4'b0001, "wrap");
    nextCycle();
    step(4'hF, 4'h0, 1'b1, 4'b0010, "wrap_ptr");
    checkVal("wrap_src", {62'd0, out_src}, 64'd0);
    nextCycle();

    // Asynchronous reset while holding 0xDEADBEEF.
    pin_beef = 1;
    step(4'b0001, 4'h0, 1'b1, 4'b0001, "beef");
    pin_beef = 0;
    nextCycle();
    step(4'hF, 4'h0, 1'b0, 4'b0000, "beef_hold");
    checkVal("beef_data", out_data, 64'hDEAD_BEEF);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkVal("arst_valid", {63'd0, out_valid}, 64'd0);
    checkVal("arst_data", out_data, 64'd0);
    checkVal("arst_ready", {60'd0, req_ready}, 64'd0);
    nextCycle();
    reset = 1'b0;
    step(4'hF, 4'h0, 1'b1, 4'b0001, "post_reset");
    nextCycle();

    // Lock scenario: requester 2 sends beats with lock 1,1,0, everyone valid.
    step(4'b0010, 4'h0, 1'b1, 4'b0010, "lock_pre");
    nextCycle();
`ifdef ARB_LOCK_EN
    lock_rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
    lock_src = '{2'd2, 2'd2, 2'd2, 2'd3};
`else
    lock_rdy = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    lock_src = '{2'd2, 2'd3, 2'd0, 2'd1};
`endif
    for (int k = 0; k < 4; k++) begin
      step(4'hF, (k < 2) ? 4'b0100 : 4'b0000, 1'b1, lock_rdy[k], "lock");
      if (k > 0) checkVal("lock_src", {62'd0, out_src}, {62'd0, lock_src[k-1]});
      nextCycle();
    end
    step(4'h0, 4'h0, 1'b1, 4'h0, "lock_tail");
    checkVal("lock_src_last", {62'd0, out_src}, {62'd0, lock_src[3]});
    nextCycle();

    // Streaming: requester 1 alone, five back-to-back beats.
    for (int k = 0; k < 5; k++) begin
      step(4'b0010, 4'h0, 1'b1, 4'b0010, "stream");
      if (k > 0) checkVal("stream_valid", {63'd0, out_valid}, 64'd1);
      nextCycle();
    end
    step(4'h0, 4'h0, 1'b1, 4'h0, "stream_tail");
    checkVal("stream_valid_last", {63'd0, out_valid}, 64'd1);
    checkVal("stream_src", {62'd0, out_src}, 64'd1);
    nextCycle();

    // Randomized traffic, occasional lock hints and resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                    $urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 59) == 0);
      nextCycle();
    end
    reset = 1'b0;
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb4_bus.md
ARB4_BUS -- requirements
Module: arb4_bus

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; sole clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  input  4  per-requester request, bit i = requester i.
REQ-004 SHALL have port: req_data  input  4x64  payload per requester, packed [3:0][63:0].
REQ-005 SHALL have port: req_lock  input  4  per-requester lock hint, meaningful only under ARB_LOCK_EN.
REQ-006 SHALL have port: req_ready  output  4  one-hot or zero; bit i high = requester i's beat accepted this cycle.
REQ-007 SHALL have port: out_valid  output  1  output slot holds a beat.
REQ-008 SHALL have port: out_data  output  64  registered payload of held beat.
REQ-009 SHALL have port: out_src  output  2  index of requester that supplied held beat.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts held beat when high with out_valid.

Function
REQ-011 SHALL implement a one-entry output slot, states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 SHALL define slot "free" in a cycle as EMPTY, or FULL with out_ready=1 (same-cycle drain and refill).
REQ-013 SHALL, when slot free and any req_valid set, pick one winner, assert its req_ready that cycle, and load req_data[winner], winner into out_data/out_src at the next edge; state -> FULL.
REQ-014 SHALL, when slot free and no req_valid set, drive req_ready=0 and go EMPTY if it was FULL.
REQ-015 SHALL drive req_ready=0 whenever slot not free; no beat is ever dropped or duplicated.
REQ-016 SHALL pick round-robin: search starts at rr_ptr, ascending modulo 4 (3 wraps to 0); first valid wins.
REQ-017 SHALL set rr_ptr = winner+1 (mod 4) on each accepted beat; rr_ptr unchanged otherwise.
REQ-018 SHALL keep out_data/out_src stable while FULL and out_ready=0.
REQ-019 SHALL ignore req_data of non-winners; req_ready SHALL depend combinationally on req_valid, state, out_ready, rr_ptr, lock state only.
REQ-020 SHALL sustain one beat per cycle when out_ready held high and requests pending.

Reset
REQ-021 SHALL, on reset assertion, immediately force out_valid=0, req_ready=0, out_data=0, out_src=0, rr_ptr=0, lock inactive, independent of clk.
REQ-022 SHALL discard a held beat if reset asserts mid-operation; first post-reset grant SHALL follow rr_ptr=0.

Configuration
REQ-023 SHALL, with macro ARB_LOCK_EN defined, set lock_active and lock_owner=winner when an accepted beat has req_lock[winner]=1.
REQ-024 SHALL, while lock_active, grant only lock_owner (others wait even if valid); lock clears when lock_owner's beat with req_lock=0 is accepted.
REQ-025 SHALL, with ARB_LOCK_EN undefined, ignore req_lock entirely and contain no lock state; port remains present.

Structure
REQ-026 SHALL place in the shared common package: constant NREQ=4, typedef word_t (64-bit), typedef src_t (2-bit), enum slot_state_t {EMPTY, FULL}.
REQ-027 SHALL factor the rotating first-valid search into one sub-module rr_pick4 (inputs 4-bit valid, 2-bit start; outputs found, 2-bit index).

Verification
REQ-028 SHALL cover: reset, all four valid, out_ready=1 for 4 cycles -> out_src sequence 0,1,2,3, req_ready one-hot 0001,0010,0100,1000.
REQ-029 SHALL cover: req_valid=1010, out_ready=0 after first load -> out_src=1, data held, req_ready=0000 until out_ready=1, then requester 3 granted.
REQ-030 SHALL cover: rr_ptr=3, only requester 0 valid -> wrap, out_src=0, rr_ptr becomes 1.
REQ-031 SHALL cover: reset asserted mid-cycle while FULL with out_data=0xDEAD_BEEF -> out_valid=0, out_data=0 before next edge.
REQ-032 SHALL cover (ARB_LOCK_EN): requester 2 sends 3 beats lock=1,1,0 with all others valid -> out_src 2,2,2 then 3; without macro -> 2,3,0.
REQ-033 SHALL cover: out_ready=1 continuously with requester 1 alone valid for 5 cycles -> 5 back-to-back beats, out_valid never drops.
